// File: rtl/spi_tx_arbiter.sv
// ----------------------------------------------------------------------------
// config_pkg / spi_tx_arbiter
//
// Round-robin arbiter that shares one SPI transmitter between P_NUM_SRC
// ready/valid word producers. One word is accepted from the selected source,
// held stable until the transmitter takes it, then a programmable idle gap is
// enforced before the next grant.
//
// Ports
//   clk_100    : system clock, rising edge
//   a_rst      : asynchronous active-high reset
//   src_valid  : per-source word-available flags
//   src_data   : packed source words, source i at [i*P_DATA_WIDTH +: P_DATA_WIDTH]
//   src_mask   : per-source enable (0 = never granted)
//   src_ready  : one-hot accept strobe, combinational, IDLE only
//   tx_ready   : transmitter can take a word
//   tx_valid   : tx_data holds a valid word (registered)
//   tx_data    : word to the transmitter (registered)
//   grant_id   : index of the source that owns tx_data (registered)
//   busy       : high while offering a word or in the idle gap (registered)
// ----------------------------------------------------------------------------
package config_pkg;
    localparam int P_DATA_WIDTH = 8;
endpackage

module spi_tx_arbiter #(
    parameter int P_DATA_WIDTH = config_pkg::P_DATA_WIDTH,
    parameter int P_NUM_SRC    = 4,
    parameter int P_GAP_CYCLES = 2
) (
    input  logic                              clk_100,
    input  logic                              a_rst,
    input  logic [P_NUM_SRC-1:0]              src_valid,
    input  logic [P_NUM_SRC*P_DATA_WIDTH-1:0] src_data,
    input  logic [P_NUM_SRC-1:0]              src_mask,
    output logic [P_NUM_SRC-1:0]              src_ready,
    input  logic                              tx_ready,
    output logic                              tx_valid,
    output logic [P_DATA_WIDTH-1:0]           tx_data,
    output logic [$clog2(P_NUM_SRC)-1:0]      grant_id,
    output logic                              busy
);

    localparam int IDW      = $clog2(P_NUM_SRC);
    localparam int GW       = (P_GAP_CYCLES > 0) ? $clog2(P_GAP_CYCLES + 1) : 1;
    localparam int GAP_LOAD = (P_GAP_CYCLES > 0) ? P_GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDW-1:0]            r_last;
    logic [GW-1:0]             r_gap_cnt;
    logic                      r_tx_valid;
    logic [P_DATA_WIDTH-1:0]   r_tx_data;
    logic [IDW-1:0]            r_grant_id;
    logic                      r_busy;

    logic [P_NUM_SRC-1:0]      w_elig;
    logic                      w_found;
    logic [IDW-1:0]            w_sel;
    logic [IDW-1:0]            w_cand;
    logic [P_NUM_SRC-1:0]      w_ready;

    assign w_elig = src_valid & src_mask;

    // Search starts one past the last grant and wraps modulo P_NUM_SRC, so a
    // non-power-of-two source count never produces an out-of-range index.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= P_NUM_SRC; k++) begin
            w_cand = IDW'((int'(r_last) + k) % P_NUM_SRC);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (!a_rst && r_state == S_IDLE && w_found) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign src_ready = w_ready;

    // State register
    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (tx_ready) begin
                    w_state_nxt = (P_GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. tx_valid/busy are derived from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_gap_cnt  <= '0;
            r_last     <= IDW'(P_NUM_SRC - 1);
        end else begin
            r_tx_valid <= (w_state_nxt == S_OFFER);
            r_busy     <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && w_found) begin
                r_tx_data  <= src_data[w_sel*P_DATA_WIDTH +: P_DATA_WIDTH];
                r_grant_id <= w_sel;
                r_last     <= w_sel;
            end
            if (r_state == S_OFFER && tx_ready) begin
                r_gap_cnt <= GW'(GAP_LOAD);
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_tx_arbiter
//
// Two arbiter instances share one clock:
//   unit 0 : 4 sources, gap 2 (reset, round-robin, masking, backpressure,
//            mid-frame reset)
//   unit 1 : 3 sources, gap 0 (zero-gap throughput, non-power-of-two wrap)
// A transaction-level model (word held / cooldown cycles / last grant) is
// compared against every output on every falling edge; directed phases add
// literal expectations on grant order, spacing and data.
// ----------------------------------------------------------------------------
module tb_spi_tx_arbiter;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    // unit 0
    logic        a_rst;
    logic [3:0]  a_sv, a_sm, a_rdy;
    logic [31:0] a_sd;
    logic        a_trdy, a_tv, a_busy;
    logic [7:0]  a_td;
    logic [1:0]  a_gid;

    // unit 1
    logic        b_rst;
    logic [2:0]  b_sv, b_sm, b_rdy;
    logic [23:0] b_sd;
    logic        b_trdy, b_tv, b_busy;
    logic [7:0]  b_td;
    logic [1:0]  b_gid;

    spi_tx_arbiter #(.P_NUM_SRC(4), .P_GAP_CYCLES(2)) u_a (
        .clk_100(clk_100), .a_rst(a_rst), .src_valid(a_sv), .src_data(a_sd),
        .src_mask(a_sm), .src_ready(a_rdy), .tx_ready(a_trdy), .tx_valid(a_tv),
        .tx_data(a_td), .grant_id(a_gid), .busy(a_busy)
    );

    spi_tx_arbiter #(.P_DATA_WIDTH(8), .P_NUM_SRC(3), .P_GAP_CYCLES(0)) u_b (
        .clk_100(clk_100), .a_rst(b_rst), .src_valid(b_sv), .src_data(b_sd),
        .src_mask(b_sm), .src_ready(b_rdy), .tx_ready(b_trdy), .tx_valid(b_tv),
        .tx_data(b_td), .grant_id(b_gid), .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cfg_n [2] = '{4, 3};
    int cfg_g [2] = '{2, 0};
    int m_hold[2];
    int m_word[2];
    int m_id  [2];
    int m_cool[2];
    int m_last[2];

    task automatic model_cycle(input int u, input logic rst,
                               input logic [15:0] vld, input logic [15:0] msk,
                               input logic [127:0] dat, input logic trdy,
                               input logic [15:0] rdy, input logic tv,
                               input logic [7:0] td, input logic [3:0] gid,
                               input logic bsy);
        logic [15:0] er;
        int  sel, idx;
        bit  found;
        if (rst) begin
            m_hold[u] = 0; m_word[u] = 0; m_id[u] = 0; m_cool[u] = 0;
            m_last[u] = cfg_n[u] - 1;
        end
        er = '0; found = 0; sel = 0;
        if (!rst && m_hold[u] == 0 && m_cool[u] == 0) begin
            for (int k = 1; k <= cfg_n[u]; k++) begin
                idx = (m_last[u] + k) % cfg_n[u];
                if (!found && vld[idx] && msk[idx]) begin
                    found = 1; sel = idx;
                end
            end
        end
        if (found) er[sel] = 1'b1;
        chk($sformatf("u%0d_src_ready", u), rdy, er);
        chk($sformatf("u%0d_tx_valid", u), tv, (m_hold[u] != 0));
        chk($sformatf("u%0d_tx_data", u), td, m_word[u]);
        chk($sformatf("u%0d_grant_id", u), gid, m_id[u]);
        chk($sformatf("u%0d_busy", u), bsy, (m_hold[u] != 0 || m_cool[u] != 0));
        if (!rst) begin
            if (found) begin
                m_hold[u] = 1; m_word[u] = int'(dat[sel*8 +: 8]);
                m_id[u] = sel; m_last[u] = sel;
            end else if (m_hold[u] != 0 && trdy) begin
                m_hold[u] = 0; m_cool[u] = cfg_g[u];
            end else if (m_cool[u] > 0) begin
                m_cool[u] = m_cool[u] - 1;
            end
        end
    endtask

    always @(negedge clk_100) begin
        model_cycle(0, a_rst, 16'(a_sv), 16'(a_sm), 128'(a_sd), a_trdy,
                    16'(a_rdy), a_tv, a_td, 4'(a_gid), a_busy);
        model_cycle(1, b_rst, 16'(b_sv), 16'(b_sm), 128'(b_sd), b_trdy,
                    16'(b_rdy), b_tv, b_td, 4'(b_gid), b_busy);
    end

    // ---------------- grant / word logs ----------------
    int   a_gcyc[$], a_gidq[$], a_wordq[$], b_gcyc[$], b_gidq[$];
    logic a_tv_prev = 1'b0;

    always @(negedge clk_100) begin
        for (int i = 0; i < 4; i++) if (a_rdy[i]) begin
            a_gcyc.push_back(cyc); a_gidq.push_back(i);
        end
        for (int i = 0; i < 3; i++) if (b_rdy[i]) begin
            b_gcyc.push_back(cyc); b_gidq.push_back(i);
        end
        if (a_tv && !a_tv_prev) a_wordq.push_back(int'(a_td));
        a_tv_prev <= a_tv;
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic wait_grants(input int u, input int n, input int budget, input string nm);
        int t;
        t = 0;
        while (((u == 0) ? a_gidq.size() : b_gidq.size()) < n && t < budget) begin
            @(posedge clk_100);
            t++;
        end
        #1;
        chk(nm, ((u == 0) ? a_gidq.size() : b_gidq.size()) >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end by 500000");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s, sw, t, cnt;
        a_rst = 1'b1; a_sv = 4'hF; a_sm = 4'hF; a_trdy = 1'b0;
        a_sd  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_rst = 1'b1; b_sv = 3'b111; b_sm = 3'b111; b_trdy = 1'b1;
        b_sd  = {8'hC2, 8'hC1, 8'hC0};

        // reset and first grant
        repeat (3) @(negedge clk_100);
        chk("rst_src_ready", 32'(a_rdy), 0);
        chk("rst_tx_valid", 32'(a_tv), 0);
        chk("rst_busy", 32'(a_busy), 0);
        tick();
        a_rst = 1'b0; a_trdy = 1'b1;
        s = a_gidq.size(); sw = a_wordq.size();
        @(negedge clk_100);
        chk("first_src_ready", 32'(a_rdy), 32'h1);
        @(negedge clk_100);
        chk("first_tx_data", 32'(a_td), 32'hA0);
        chk("first_grant_id", 32'(a_gid), 0);
        chk("first_tx_valid", 32'(a_tv), 1);

        // round robin 0,1,2,3,0 spaced 4 cycles
        wait_grants(0, s + 5, 40, "rr_timeout");
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_id%0d", k), a_gidq[s+k], k % 4);
            chk($sformatf("rr_word%0d", k), a_wordq[sw+k], 32'hA0 + (k % 4));
            if (k > 0) chk($sformatf("rr_space%0d", k), a_gcyc[s+k] - a_gcyc[s+k-1], 4);
        end

        // masking
        a_sm = 4'b1010;
        s = a_gidq.size();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_100);
            chk("mask_ready02", {30'd0, a_rdy[2], a_rdy[0]}, 0);
        end
        tick();
        chk("mask_count", (a_gidq.size() - s) >= 4, 1);
        for (int k = s; k < a_gidq.size(); k++) begin
            chk("mask_id", (a_gidq[k] == 1 || a_gidq[k] == 3), 1);
            if (k > s) chk("mask_alt", (a_gidq[k] != a_gidq[k-1]), 1);
        end

        // backpressure on source 2
        a_sv = 4'h0; a_sm = 4'hF;
        repeat (6) tick();
        a_trdy = 1'b0; a_sd[23:16] = 8'h5C; a_sv = 4'b0100;
        t = 0;
        while (!a_tv && t < 10) begin tick(); t++; end
        chk("bp_grant_seen", 32'(a_tv), 1);
        a_sd[23:16] = 8'h77; a_sv = 4'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_100);
            chk("bp_tx_valid", 32'(a_tv), 1);
            chk("bp_tx_data", 32'(a_td), 32'h5C);
            chk("bp_grant_id", 32'(a_gid), 2);
        end
        tick();
        a_trdy = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_100);
            cnt += int'(a_tv);
        end
        chk("bp_one_handshake", cnt, 1);
        chk("bp_tx_valid_after", 32'(a_tv), 0);

        // mid-frame reset: source 3 is next, its word is dropped
        tick();
        a_trdy = 1'b0; a_sd = {8'hB3, 8'hB2, 8'hB1, 8'hB0}; a_sv = 4'hF;
        t = 0;
        while (!a_tv && t < 10) begin tick(); t++; end
        chk("mf_offer_seen", 32'(a_tv), 1);
        @(negedge clk_100);
        chk("mf_pre_grant_id", 32'(a_gid), 3);
        chk("mf_pre_tx_data", 32'(a_td), 32'hB3);
        @(posedge clk_100);
        #3 a_rst = 1'b1;
        #1;
        chk("mf_tx_valid_async", 32'(a_tv), 0);
        chk("mf_busy_async", 32'(a_busy), 0);
        chk("mf_src_ready", 32'(a_rdy), 0);
        tick();
        a_rst = 1'b0; a_trdy = 1'b1;
        s = a_gidq.size(); sw = a_wordq.size();
        wait_grants(0, s + 1, 10, "mf_timeout");
        repeat (2) tick();
        chk("mf_restart_id", a_gidq[s], 0);
        chk("mf_restart_word", a_wordq[sw], 32'hB0);

        // zero gap, 3 sources
        s = b_gidq.size();
        b_rst = 1'b0;
        wait_grants(1, s + 6, 30, "zg_timeout");
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("zg_id%0d", k), b_gidq[s+k], k % 3);
            if (k > 0) chk($sformatf("zg_space%0d", k), b_gcyc[s+k] - b_gcyc[s+k-1], 2);
        end
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin arbiter that shares the single SPI transmitter between up to P_NUM_SRC independent frame producers. It sits between the producers (data_former-style ready/valid sources) and the transmitter's ready/valid/data input. It accepts one word at a time from the selected source, holds it stable until the transmitter takes it, and then enforces a programmable idle gap before the next grant.

## Interface
- P_DATA_WIDTH, default config_pkg::P_DATA_WIDTH: word width, matches the transmitter's data port.
- P_NUM_SRC, default 4: number of requesters; legal range is 2..16.
- P_GAP_CYCLES, default 2: minimum idle cycles after a transmitter handshake before the next grant; 0 is legal.
- clk_100  input  1  system clock, all logic on the rising edge.
- a_rst  input  1  asynchronous, active-high reset.
- src_valid  input  P_NUM_SRC  per-source word-available flag.
- src_data  input  P_NUM_SRC*P_DATA_WIDTH  packed source words; source i occupies bits [i*P_DATA_WIDTH +: P_DATA_WIDTH].
- src_mask  input  P_NUM_SRC  per-source enable; 0 means the source is never granted.
- src_ready  output  P_NUM_SRC  one-hot accept strobe (combinational).
- tx_ready  input  1  transmitter can accept a word.
- tx_valid  output  1  word on tx_data is valid.
- tx_data  output  P_DATA_WIDTH  word to the transmitter.
- grant_id  output  $clog2(P_NUM_SRC)  index of the source that owns tx_data.
- busy  output  1  high in OFFER and GAP.

## Operation
- The FSM has three states: IDLE, OFFER, GAP. The reset state is IDLE.
- A source is eligible when src_valid[i] and src_mask[i] are both high.
- IDLE behaviour:
  - The search starts at (last_grant+1) mod P_NUM_SRC and moves upward with wrap-around. The first eligible index becomes sel.
  - If at least one source is eligible, src_ready[sel] is 1 in that cycle.
  - On that edge the block latches tx_data<=src_data[sel], grant_id<=sel and last_grant<=sel, then moves to OFFER.
  - With no eligible source, src_ready is 0 and the FSM stays in IDLE.
- OFFER behaviour:
  - tx_valid=1. tx_data and grant_id are held constant.
  - src_ready is all-zero.
  - On the edge where tx_valid and tx_ready are both high (the handshake): if P_GAP_CYCLES=0, go to IDLE; otherwise load gap_cnt<=P_GAP_CYCLES-1 and go to GAP.
- GAP behaviour:
  - tx_valid=0 and src_ready is all-zero.
  - gap_cnt decrements each cycle. When gap_cnt=0, go to IDLE.
  - gap_cnt width is $clog2(P_GAP_CYCLES+1), with a minimum of 1.
- tx_valid, tx_data, grant_id and busy are registered. src_ready is combinational from state, the pointer, src_valid and src_mask.
- While a_rst is high, src_ready is forced to 0.
- last_grant resets to P_NUM_SRC-1, so source 0 has first priority after reset.
- Boundary conditions:
  - A source with src_valid high but src_mask low is skipped and never gets src_ready.
  - Changes to src_mask or src_valid during OFFER or GAP do not affect the word already latched.
  - If tx_ready is already high on the first OFFER cycle, the handshake happens on that edge: OFFER lasts exactly one cycle.
  - When only one source is eligible, it is re-granted every round, with no starvation penalty.
  - P_NUM_SRC that is not a power of two: the pointer wraps at P_NUM_SRC-1 and never reaches an out-of-range index.
- Reset mid-operation: an asserted a_rst immediately clears tx_valid, tx_data, grant_id, busy, gap_cnt and the state. Any word in flight is dropped and is not replayed.

## Timing
- Reset values: tx_valid=0, tx_data=0, grant_id=0, busy=0, src_ready=0, state=IDLE.
- Accept latency: src_ready[i] is high in cycle k (IDLE). tx_valid and busy are high from cycle k+1.
- Handshake: if tx_ready is first high in cycle m ≥ k+1, the handshake occurs on edge m. tx_valid=0 from cycle m+1.
- Gap: with P_GAP_CYCLES=G>0, the FSM is in GAP for cycles m+1 through m+G and in IDLE from cycle m+G+1. The earliest next src_ready is in cycle m+G+1.
- Back-to-back throughput: with tx_ready held high, one word every G+2 cycles.

## Test plan
- Reset and idle:
  - Stimulus: assert a_rst with src_valid=4'b1111.
  - Required response: src_ready=0 and tx_valid=0 during reset.
  - After reset release: src_ready=4'b0001 in the first cycle; tx_data equals src_data[0] and grant_id=0 on the next cycle.
- Round-robin fairness:
  - Stimulus: all sources valid with constant words 0xA0..0xA3; tx_ready=1; G=2.
  - Required response: grants occur in order 0,1,2,3,0, spaced 4 cycles apart, with matching tx_data.
- Masking:
  - Stimulus: src_mask=4'b1010, all sources valid.
  - Required response: only sources 1 and 3 are granted, alternating; src_ready[0] and src_ready[2] are never high.
- Backpressure:
  - Stimulus: hold tx_ready=0 for 10 cycles after a grant from source 2 with word 0x5C, while changing src_data[2].
  - Required response: tx_valid stays 1 and tx_data stays 0x5C for all 10 cycles.
  - After tx_ready rises: exactly one handshake occurs, then tx_valid=0.
- Zero gap:
  - Stimulus: P_GAP_CYCLES=0 with tx_ready=1.
  - Required response: a new word is accepted every 2 cycles; the FSM never enters GAP.
- Mid-frame reset:
  - Stimulus: pulse a_rst during OFFER.
  - Required response: tx_valid drops asynchronously.
  - After release: the round-robin pointer restarts at source 0, and the dropped word is never transmitted.
